// File: rtl/bounce_accumulator_array_if.sv
// Step/clear request bus and per-channel status bus for bounce_accumulator_array.
// The master drives steps and clears; the slave returns packed per-channel state.
interface bounce_accumulator_array_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    step_valid;
  logic                    step_ready;
  logic [CH_W-1:0]         step_ch;
  logic [WIDTH-1:0]        step_value;
  logic [1:0]              mode;
  logic                    clr_valid;
  logic [CH_W-1:0]         clr_ch;
  logic [NUM_CH*WIDTH-1:0] acc_value;
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH-1:0]       turn_pulse;
  logic [NUM_CH*CNT_W-1:0] turn_count;

  modport master (
    output step_valid, step_ch, step_value, mode, clr_valid, clr_ch,
    input  step_ready, acc_value, dir, turn_pulse, turn_count
  );

  modport slave (
    input  step_valid, step_ch, step_value, mode, clr_valid, clr_ch,
    output step_ready, acc_value, dir, turn_pulse, turn_count
  );
endinterface

// File: rtl/bounce_accumulator_array.sv
// NUM_CH independent signed accumulators that bounce between two thresholds (legacy/clamp/wrap).
// All outputs registered: a step accepted at edge N is visible after edge N; ready is 1 except in reset.
module bounce_accumulator_array #(
  parameter int WIDTH         = 32,
  parameter int NUM_CH        = 4,
  parameter int MAX_THRESHOLD = 100,
  parameter int MIN_THRESHOLD = 0,
  parameter int CNT_W         = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic                      clk,
  input logic                      rst,
  bounce_accumulator_array_if.slave bus
);
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic signed [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_THRESHOLD);
  localparam logic signed [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_THRESHOLD);

  // Clamp mode only: a result outside the WIDTH range pins to the signed limit.
  function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1])
      return x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return x[WIDTH-1:0];
  endfunction

  logic [NUM_CH-1:0][WIDTH-1:0] r_acc;
  logic [NUM_CH-1:0][WIDTH-1:0] w_nxt_acc;
  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;
  dir_e                         r_dir     [NUM_CH];
  dir_e                         w_nxt_dir [NUM_CH];
  logic [NUM_CH-1:0]            w_turn;
  logic [NUM_CH-1:0]            r_pulse;
  logic [NUM_CH-1:0]            w_step_hit;
  logic [NUM_CH-1:0]            w_clr_hit;
  logic                         r_ready;
  logic signed [WIDTH:0]        w_step_x;
  logic signed [WIDTH:0]        w_acc_x [NUM_CH];
  logic signed [WIDTH:0]        w_sum   [NUM_CH];
  logic signed [WIDTH:0]        w_dif   [NUM_CH];

  assign w_step_x = {bus.step_value[WIDTH-1], bus.step_value};

  // Next state for every channel as if it were addressed; the register stage picks the target.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_acc_x[c]    = {r_acc[c][WIDTH-1], r_acc[c]};
      w_sum[c]      = w_acc_x[c] + w_step_x;
      w_dif[c]      = w_acc_x[c] - w_step_x;
      w_step_hit[c] = bus.step_valid && r_ready && (bus.step_ch == CH_W'(c));
      w_clr_hit[c]  = bus.clr_valid && (bus.clr_ch == CH_W'(c));
      w_nxt_acc[c]  = r_acc[c];
      w_nxt_dir[c]  = r_dir[c];
      w_turn[c]     = 1'b0;
      case (bus.mode)
        2'd1: begin
          if (r_dir[c] == DIR_UP) begin
            if (w_sum[c] >= MAX_X) begin
              w_nxt_acc[c] = MAX_X[WIDTH-1:0];
              w_nxt_dir[c] = DIR_DOWN;
              w_turn[c]    = 1'b1;
            end else begin
              w_nxt_acc[c] = sat(w_sum[c]);
            end
          end else begin
            if (w_dif[c] <= MIN_X) begin
              w_nxt_acc[c] = MIN_X[WIDTH-1:0];
              w_nxt_dir[c] = DIR_UP;
              w_turn[c]    = 1'b1;
            end else begin
              w_nxt_acc[c] = sat(w_dif[c]);
            end
          end
        end
        2'd2: begin
          if (w_sum[c] > MAX_X) begin
            w_nxt_acc[c] = MIN_X[WIDTH-1:0];
            w_turn[c]    = 1'b1;
          end else if (w_sum[c] < MIN_X) begin
            w_nxt_acc[c] = MAX_X[WIDTH-1:0];
            w_turn[c]    = 1'b1;
          end else begin
            w_nxt_acc[c] = w_sum[c][WIDTH-1:0];
          end
        end
        default: begin
          // Legacy: the step that finds the accumulator at a threshold is spent on the turn.
          if (r_dir[c] == DIR_UP) begin
            if (w_acc_x[c] >= MAX_X) begin
              w_nxt_dir[c] = DIR_DOWN;
              w_turn[c]    = 1'b1;
            end else begin
              w_nxt_acc[c] = w_sum[c][WIDTH-1:0];
            end
          end else begin
            if (w_acc_x[c] <= MIN_X) begin
              w_nxt_dir[c] = DIR_UP;
              w_turn[c]    = 1'b1;
            end else begin
              w_nxt_acc[c] = w_dif[c][WIDTH-1:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c]   <= '0;
        r_dir[c]   <= DIR_UP;
        r_cnt[c]   <= '0;
        r_pulse[c] <= 1'b0;
      end
    end else begin
      r_ready <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pulse[c] <= 1'b0;
        if (w_clr_hit[c]) begin
          r_acc[c] <= '0;
          r_dir[c] <= DIR_UP;
          r_cnt[c] <= '0;
        end else if (w_step_hit[c]) begin
          r_acc[c]   <= w_nxt_acc[c];
          r_dir[c]   <= w_nxt_dir[c];
          r_pulse[c] <= w_turn[c];
          if (w_turn[c] && (r_cnt[c] != {CNT_W{1'b1}}))
            r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) bus.dir[c] = r_dir[c];
  end

  assign bus.step_ready = r_ready;
  assign bus.acc_value  = r_acc;
  assign bus.turn_pulse = r_pulse;
  assign bus.turn_count = r_cnt;
endmodule

// File: tb/tb_bounce_accumulator_array.sv
// Directed plus randomized checks of bounce_accumulator_array against an integer reference model.
module tb_bounce_accumulator_array;
  localparam int W    = 32;
  localparam int NCH  = 5;
  localparam int MAXT = 100;
  localparam int MINT = 0;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam longint WMAX = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint WMIN = -(64'sd1 <<< (W-1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bounce_accumulator_array_if #(.WIDTH(W), .NUM_CH(NCH), .CNT_W(CW)) bus ();

  bounce_accumulator_array #(
    .WIDTH(W), .NUM_CH(NCH), .MAX_THRESHOLD(MAXT), .MIN_THRESHOLD(MINT), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  longint m_acc   [NCH];
  bit     m_dir   [NCH];
  int     m_cnt   [NCH];
  bit     m_pulse [NCH];
  bit     m_ready;

  function automatic longint wrapw(input longint x);
    logic [W-1:0] t;
    t = x[W-1:0];
    return longint'($signed(t));
  endfunction

  function automatic longint satw(input longint x);
    if (x > WMAX) return WMAX;
    if (x < WMIN) return WMIN;
    return x;
  endfunction

  task automatic model_turn(input int c);
    m_pulse[c] = 1'b1;
    if (m_cnt[c] < CMAX) m_cnt[c]++;
  endtask

  task automatic model_step(input int c, input logic [W-1:0] v, input int md);
    longint a, s, n;
    a = m_acc[c];
    s = longint'($signed(v));
    if (md == 1) begin
      n = m_dir[c] ? a - s : a + s;
      if (!m_dir[c] && n >= MAXT) begin
        a = MAXT; m_dir[c] = 1'b1; model_turn(c);
      end else if (m_dir[c] && n <= MINT) begin
        a = MINT; m_dir[c] = 1'b0; model_turn(c);
      end else begin
        a = satw(n);
      end
    end else if (md == 2) begin
      n = a + s;
      if (n > MAXT) begin a = MINT; model_turn(c); end
      else if (n < MINT) begin a = MAXT; model_turn(c); end
      else a = n;
    end else begin
      if (!m_dir[c] && a >= MAXT) begin
        m_dir[c] = 1'b1; model_turn(c);
      end else if (m_dir[c] && a <= MINT) begin
        m_dir[c] = 1'b0; model_turn(c);
      end else begin
        a = wrapw(m_dir[c] ? a - s : a + s);
      end
    end
    m_acc[c] = a;
  endtask

  task automatic model_edge(input bit r, input bit sv, input int ch, input logic [W-1:0] v,
                            input int md, input bit cv, input int cc);
    for (int c = 0; c < NCH; c++) m_pulse[c] = 1'b0;
    if (r) begin
      m_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_dir[c] = 1'b0; m_cnt[c] = 0;
      end
    end else begin
      if (sv && m_ready && ch < NCH && !(cv && cc == ch)) model_step(ch, v, md);
      if (cv && cc < NCH) begin
        m_acc[cc] = 0; m_dir[cc] = 1'b0; m_cnt[cc] = 0;
      end
      m_ready = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] ea;
    check("step_ready", 64'(bus.step_ready), 64'(m_ready));
    for (int c = 0; c < NCH; c++) begin
      ea = m_acc[c][W-1:0];
      check($sformatf("acc%0d", c), 64'(bus.acc_value[c*W +: W]), 64'(ea));
      check($sformatf("dir%0d", c), 64'(bus.dir[c]), 64'(m_dir[c]));
      check($sformatf("pulse%0d", c), 64'(bus.turn_pulse[c]), 64'(m_pulse[c]));
      check($sformatf("cnt%0d", c), 64'(bus.turn_count[c*CW +: CW]), 64'(m_cnt[c]));
    end
  endtask

  task automatic cyc(input bit r, input bit sv, input int ch, input logic [W-1:0] v,
                     input int md, input bit cv, input int cc);
    rst            = r;
    bus.step_valid = sv;
    bus.step_ch    = 3'(ch);
    bus.step_value = v;
    bus.mode       = 2'(md);
    bus.clr_valid  = cv;
    bus.clr_ch     = 3'(cc);
    @(posedge clk);
    model_edge(r, sv, ch, v, md, cv, cc);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int md, ch, cc;
    bit sv, cv;
    logic [W-1:0] v;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_ready_low", 64'(bus.step_ready), 64'd0);
    cyc(0, 1, 0, 30, 0, 0, 0);
    check("ready_after_release", 64'(bus.step_ready), 64'd1);
    check("release_step_dropped", 64'(bus.acc_value[W-1:0]), 64'd0);

    // Legacy: 30,60,90,120, turn holding 120, 90..0, turn back up.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 30, 0, 0, 0);
      if (i == 3) check("t1_acc120", 64'(bus.acc_value[W-1:0]), 64'd120);
      if (i == 4) begin
        check("t1_turn_hold", 64'(bus.acc_value[W-1:0]), 64'd120);
        check("t1_turn_pulse", 64'(bus.turn_pulse[0]), 64'd1);
      end
    end
    check("t1_cnt2", 64'(bus.turn_count[CW-1:0]), 64'd2);

    // Clamp: 40,80,100(down),60,20,0(up).
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 40, 1, 0, 0);
      if (i == 2) begin
        check("t2_clamp_max", 64'(bus.acc_value[W +: W]), 64'd100);
        check("t2_dir_down", 64'(bus.dir[1]), 64'd1);
      end
    end
    check("t2_cnt2", 64'(bus.turn_count[CW +: CW]), 64'd2);

    // Wrap: 45,90,wrap to 0, then -10 wraps to 100.
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, 45, 2, 0, 0);
    check("t3_wrap_min", 64'(bus.acc_value[2*W +: W]), 64'd0);
    check("t3_wrap_pulse", 64'(bus.turn_pulse[2]), 64'd1);
    cyc(0, 1, 2, -10, 2, 0, 0);
    check("t3_wrap_max", 64'(bus.acc_value[2*W +: W]), 64'd100);

    // Step and clear together on ch3, then step ch0 with clear ch3.
    cyc(0, 1, 3, 50, 1, 0, 0);
    cyc(0, 1, 3, 7, 1, 1, 3);
    check("t4_clear_wins", 64'(bus.acc_value[3*W +: W]), 64'd0);
    cyc(0, 1, 0, 30, 0, 1, 3);
    check("t4_both_applied", 64'(bus.acc_value[W-1:0]), 64'd30);

    // Counter saturation via repeated wraps on ch4.
    for (int i = 0; i < 5; i++) cyc(0, 1, 4, 101, 2, 0, 0);
    check("t5_cnt_sat", 64'(bus.turn_count[4*CW +: CW]), 64'd3);
    check("t5_pulse_at_sat", 64'(bus.turn_pulse[4]), 64'd1);

    // Channel indices past NUM_CH are accepted and discarded.
    cyc(0, 1, 5, 20, 0, 0, 0);
    cyc(0, 1, 7, 20, 1, 1, 6);

    for (int i = 0; i < 300; i++) begin
      md = $urandom_range(0, 3);
      ch = $urandom_range(0, 7);
      cc = $urandom_range(0, 7);
      sv = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) v = $urandom();
      else v = 32'($urandom_range(0, 120)) - 32'd40;
      cyc(0, sv, ch, v, md, cv, cc);
    end

    // Reset mid-run with a step pending.
    cyc(1, 1, 0, 5, 0, 0, 0);
    cyc(1, 1, 0, 5, 0, 0, 0);
    check("rst2_ready_low", 64'(bus.step_ready), 64'd0);
    cyc(0, 1, 0, 5, 0, 0, 0);
    check("rst2_ready_back", 64'(bus.step_ready), 64'd1);
    check("rst2_acc_zero", 64'(bus.acc_value[W-1:0]), 64'd0);
    cyc(0, 1, 0, 5, 0, 0, 0);
    check("rst2_first_step", 64'(bus.acc_value[W-1:0]), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bounce_accumulator_array.md
Name: bounce_accumulator_array

Overview:
- Multi-channel, parametrised successor of the single-channel ping-pong accumulator.
- Each of NUM_CH independent channels holds a signed accumulator. On each accepted step, the channel adds or subtracts that step according to its direction.
- Three run-time modes control what happens at the thresholds: legacy turn, clamp-and-turn, and wrap.
- Sits between a step source (stimulus/sequencer) and downstream display/compare logic. Exports per-channel value, direction, turn pulses and saturating turn counters.

Parameters:
- WIDTH, 32, accumulator and step width (signed, two's complement).
- NUM_CH, 4, number of independent channels (>=1).
- MAX_THRESHOLD, 100, upper turn threshold (signed, representable in WIDTH; must be > MIN_THRESHOLD).
- MIN_THRESHOLD, 0, lower turn threshold (signed, representable in WIDTH).
- CNT_W, 16, width of each per-channel turn counter.
- CH_W, $clog2(NUM_CH) (min 1), channel index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- step_valid  in  1  step request.
- step_ready  out  1  block can accept a step this cycle.
- step_ch  in  CH_W  target channel of the step; values >= NUM_CH are accepted and discarded.
- step_value  in  WIDTH  signed step magnitude.
- mode  in  2  0=legacy, 1=clamp, 2=wrap, 3=reserved (behaves as 0); sampled per accepted step.
- clr_valid  in  1  clear request for channel clr_ch.
- clr_ch  in  CH_W  channel to clear.
- acc_value  out  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- dir  out  NUM_CH  per channel: 0=UP (adding), 1=DOWN (subtracting).
- turn_pulse  out  NUM_CH  one-cycle pulse, asserted in the cycle the new direction becomes visible.
- turn_count  out  NUM_CH*CNT_W  per-channel count of direction changes, saturating.

Behaviour:
- Reset (rst=1 at a clock edge), for every channel:
  - acc_value=0, dir=UP, turn_pulse=0, turn_count=0.
  - step_ready=0 during reset; it rises in the first cycle after rst is sampled low and stays 1 thereafter.
  - Reset asserted mid-operation discards the step in flight; no partial update.
- Accept: a step is accepted when step_valid && step_ready at a rising edge. At most one step per cycle.
- Latency: all outputs are registered. The updated acc_value, dir, turn_pulse and turn_count are visible 1 cycle after acceptance. Channels not addressed hold their values.
- Arithmetic: next = acc ± step_value, computed in WIDTH+1 bits signed. All threshold comparisons use the WIDTH+1 result.
- Mode 0 (legacy), 2-state FSM per channel:
  - UP: if acc >= MAX, set dir<=DOWN and do not change acc (the step is consumed by the turn). Otherwise acc <= low WIDTH bits of acc+step.
  - DOWN: if acc <= MIN, set dir<=UP and do not change acc. Otherwise acc <= acc-step, truncated.
  - Overflow wraps, matching the original block.
- Mode 1 (clamp):
  - UP: next=acc+step. If next >= MAX, acc<=MAX and dir<=DOWN in the same update. Otherwise acc<=next.
  - DOWN: next=acc-step. If next <= MIN, acc<=MIN and dir<=UP. Otherwise acc<=next.
  - Only the threshold for the current direction is checked. A negative step may carry acc past the opposite threshold without a turn or a clamp; if the result exceeds the WIDTH range, it saturates to the WIDTH signed limits.
- Mode 2 (wrap):
  - Always adds; dir is held unchanged.
  - next=acc+step. If next > MAX, acc<=MIN. If next < MIN, acc<=MAX. Otherwise acc<=next.
  - A wrap counts as a turn: turn_pulse fires and turn_count increments.
- Turn bookkeeping:
  - turn_pulse[c]=1 for exactly the one cycle in which the channel's dir change (or wrap) becomes visible; 0 in all other cycles.
  - turn_count[c] increments by 1 per turn and holds at 2^CNT_W-1.
- Mode switching: per accepted step, the mode applies to the channel's current acc/dir. No state is reset on a mode change.
- Clear: when clr_valid at an edge, channel clr_ch gets acc=0, dir=UP, turn_count=0, turn_pulse=0 on the next cycle. clr_ch >= NUM_CH is ignored.
- Simultaneous step and clear:
  - Same channel: the clear wins and the step is dropped (it still counts as accepted).
  - Different channels: both take effect in the same cycle.
- step_value=0: acc is unchanged; in mode 0 a turn still occurs if at threshold.

Test Plan:
- Reset then mode 0, ch0, step 30 every cycle -> acc 30,60,90,120; next accept: dir=DOWN, acc stays 120, turn_pulse[0] for 1 cycle; then 90,60,30,0; next accept: turn to UP; turn_count[0]=2.
- Mode 1, ch1, step 40 -> 40,80,100 (clamped) with dir=DOWN in the same update; then 60,20,0 (clamped) with dir=UP; turn_count[1]=2; ch0/2/3 unchanged.
- Mode 2, ch2, step 45 -> 45,90, then 0 (135>100 wraps to MIN); turn_pulse[2]=1, dir stays UP; step -10 from 0 -> acc=100.
- Same-cycle step and clear on ch3 with acc=50 -> next cycle acc=0, dir=UP, count=0. Same-cycle step on ch0 and clear on ch3 -> both applied.
- CNT_W=2: force 5 turns on ch0 -> turn_count saturates at 3 while turn_pulse still fires each turn. Step_ch=NUM_CH (if representable) -> all channels unchanged.
- Assert rst mid-run with step_valid high -> all accumulators 0, step_ready=0 during reset and back to 1 one cycle after release; the first post-reset step applies from 0.
